// File: rtl/pxs_sync_gen_pkg.sv
// Shared types and stream field positions for the iPxs sync generator.
// Stream layout: {HS, VS, XC[9:0], YC[9:0], Active}, 23 bits.
package pxs_sync_gen_pkg;

    localparam int CW      = 10;
    localparam int STR_W   = 23;
    localparam int HS_BIT  = 22;
    localparam int VS_BIT  = 21;
    localparam int XC_HI   = 20;
    localparam int XC_LO   = 11;
    localparam int YC_HI   = 10;
    localparam int YC_LO   = 1;
    localparam int ACT_BIT = 0;

    typedef logic [CW-1:0]    coord_t;
    typedef logic [CW:0]      wide_t;
    typedef logic [STR_W-1:0] str_t;

    function automatic str_t pack_str(
        input logic   hs,
        input logic   vs,
        input coord_t xc,
        input coord_t yc,
        input logic   act
    );
        str_t s;
        s                = '0;
        s[HS_BIT]        = hs;
        s[VS_BIT]        = vs;
        s[XC_HI:XC_LO]   = xc;
        s[YC_HI:YC_LO]   = yc;
        s[ACT_BIT]       = act;
        return s;
    endfunction

endpackage

// File: rtl/pxs_sync_gen_if.sv
// iPxs head-of-chain stream bundle: advance enable in, stream and frame pulse out.
// master: the generator (drives stream); slave: the downstream consumer.
interface pxs_sync_gen_if;
    import pxs_sync_gen_pkg::*;

    logic en;
    str_t VGAStr_o;
    logic frame_o;

    modport master (
        input  en,
        output VGAStr_o,
        output frame_o
    );

    modport slave (
        output en,
        input  VGAStr_o,
        input  frame_o
    );

endinterface

// File: rtl/pxs_sync_gen_axis_counter.sv
// Modulo-N axis counter with enable, terminal count and window decode.
// Ports: clk, rst (async high), en; cnt, tc (cnt==N-1), win (POL inside
// [START, START+WIDTH), ~POL outside), act (cnt < ACT).
module pxs_axis_counter
    import pxs_sync_gen_pkg::*;
#(
    parameter int N     = 800,
    parameter int START = 656,
    parameter int WIDTH = 96,
    parameter int ACT   = 640,
    parameter bit POL   = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t cnt,
    output logic   tc,
    output logic   win,
    output logic   act
);

    localparam coord_t LAST  = coord_t'(N - 1);
    localparam wide_t  W_LO  = wide_t'(START);
    localparam wide_t  W_HI  = wide_t'(START + WIDTH);
    localparam wide_t  A_LIM = wide_t'(ACT);

    wide_t cnt_w;

    assign cnt_w = {1'b0, cnt};
    assign tc    = (cnt == LAST);
    assign win   = (cnt_w >= W_LO && cnt_w < W_HI) ? POL : ~POL;
    assign act   = (cnt_w < A_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + coord_t'(1);
        end
    end

endmodule

// File: rtl/pxs_sync_gen.sv
// VGA timing generator emitting the registered RGB-less iPxs stream.
// Ports: px_clk, reset (async high); pxs.en in, pxs.VGAStr_o / pxs.frame_o out.
module pxs_sync_gen
    import pxs_sync_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic           px_clk,
    input  logic           reset,
    pxs_sync_gen_if.master pxs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("pxs_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    coord_t hcnt;
    coord_t vcnt;
    logic   h_tc;
    logic   h_win;
    logic   h_act;
    logic   v_tc_unused;
    logic   v_win;
    logic   v_act;

    pxs_axis_counter #(
        .N     (H_TOTAL),
        .START (H_ACTIVE + H_FP),
        .WIDTH (H_SYNC),
        .ACT   (H_ACTIVE),
        .POL   (HS_POL)
    ) u_h (
        .clk (px_clk),
        .rst (reset),
        .en  (pxs.en),
        .cnt (hcnt),
        .tc  (h_tc),
        .win (h_win),
        .act (h_act)
    );

    // Vertical advances only on the edge where the line wraps.
    pxs_axis_counter #(
        .N     (V_TOTAL),
        .START (V_ACTIVE + V_FP),
        .WIDTH (V_SYNC),
        .ACT   (V_ACTIVE),
        .POL   (VS_POL)
    ) u_v (
        .clk (px_clk),
        .rst (reset),
        .en  (pxs.en & h_tc),
        .cnt (vcnt),
        .tc  (v_tc_unused),
        .win (v_win),
        .act (v_act)
    );

    // Every field is sampled from the same pre-increment counts, so all
    // fields carry the same one-clock latency.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            pxs.VGAStr_o <= pack_str(~HS_POL, ~VS_POL, '0, '0, 1'b0);
            pxs.frame_o  <= 1'b0;
        end else begin
            pxs.frame_o <= pxs.en && (hcnt == '0) && (vcnt == '0);
            if (pxs.en) begin
                pxs.VGAStr_o <= pack_str(h_win, v_win, hcnt, vcnt,
                                         h_act & v_act);
            end
        end
    end

endmodule

// File: tb/tb_pxs_sync_gen.sv
// Self-checking bench for pxs_sync_gen: default 640x480 timing plus a
// small custom timing checked against a reference model.
module tb_pxs_sync_gen;

    typedef struct {
        int pix;
        int xc;
        int yc;
        bit act;
        bit hs;
        bit vs;
        bit fr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   dpix   = -1;
    int   mh     = 0;
    int   mv     = 0;
    logic [22:0] sexp;

    pxs_sync_gen_if dbus ();
    pxs_sync_gen_if sbus ();

    pxs_sync_gen u_def (
        .px_clk (clk),
        .reset  (rst),
        .pxs    (dbus)
    );

    pxs_sync_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (2),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0)
    ) u_sml (
        .px_clk (clk),
        .reset  (rst),
        .pxs    (sbus)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] w(input bit hs, input bit vs,
                                      input int xc, input int yc,
                                      input bit act);
        return {hs, vs, 10'(xc), 10'(yc), act};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dstep;
        tick();
        dpix++;
    endtask

    // Reference model for the 16x8 timing: HS high for h 10..12,
    // VS low for v 5, Active for h<8 and v<4.
    task automatic sm_cycle(input bit e, output bit fr);
        logic efr;
        sbus.en = e;
        efr = 1'b0;
        if (e) begin
            sexp = w(mh >= 10 && mh < 13, mv != 5, mh, mv,
                     mh < 8 && mv < 4);
            efr = (mh == 0 && mv == 0);
        end
        tick();
        chk("sml_str", sbus.VGAStr_o, sexp);
        chk("sml_frame", sbus.frame_o, efr);
        fr = sbus.frame_o;
        if (e) begin
            mh = (mh == 15) ? 0 : mh + 1;
            if (mh == 0) mv = (mv == 7) ? 0 : mv + 1;
        end
    endtask

    initial begin
        vec_t tbl [13];
        int   na;
        int   nh;
        int   fhs;
        int   nf;
        int   last;
        bit   fr;
        bit   found;

        tbl[0]  = '{0,    0,   0, 1, 1, 1, 1};
        tbl[1]  = '{1,    1,   0, 1, 1, 1, 0};
        tbl[2]  = '{639,  639, 0, 1, 1, 1, 0};
        tbl[3]  = '{640,  640, 0, 0, 1, 1, 0};
        tbl[4]  = '{655,  655, 0, 0, 1, 1, 0};
        tbl[5]  = '{656,  656, 0, 0, 0, 1, 0};
        tbl[6]  = '{751,  751, 0, 0, 0, 1, 0};
        tbl[7]  = '{752,  752, 0, 0, 1, 1, 0};
        tbl[8]  = '{799,  799, 0, 0, 1, 1, 0};
        tbl[9]  = '{800,  0,   1, 1, 1, 1, 0};
        tbl[10] = '{4799, 799, 5, 0, 1, 1, 0};
        tbl[11] = '{4800, 0,   6, 1, 1, 1, 0};
        tbl[12] = '{4900, 100, 6, 1, 1, 1, 0};

        rst = 1'b1;
        dbus.en = 1'b1;
        sbus.en = 1'b0;
        sexp = w(0, 1, 0, 0, 0);
        #2;
        chk("reset_def_str", dbus.VGAStr_o, w(1, 1, 0, 0, 0));
        chk("reset_def_frame", dbus.frame_o, 0);
        chk("reset_sml_str", sbus.VGAStr_o, w(0, 1, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            while (dpix < tbl[i].pix) dstep();
            chk($sformatf("def_vec%0d_str", i), dbus.VGAStr_o,
                w(tbl[i].hs, tbl[i].vs, tbl[i].xc, tbl[i].yc, tbl[i].act));
            chk($sformatf("def_vec%0d_frame", i), dbus.frame_o, tbl[i].fr);
        end

        dbus.en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("stall_hold", dbus.VGAStr_o, w(1, 1, 100, 6, 1));
            chk("stall_frame", dbus.frame_o, 0);
        end
        dbus.en = 1'b1;
        dstep();
        chk("resume_101", dbus.VGAStr_o, w(1, 1, 101, 6, 1));
        dstep();
        chk("resume_102", dbus.VGAStr_o, w(1, 1, 102, 6, 1));

        while (dpix < 5599) dstep();
        na = 0;
        nh = 0;
        fhs = -1;
        for (int i = 0; i < 800; i++) begin
            dstep();
            if (dbus.VGAStr_o[0]) na++;
            if (!dbus.VGAStr_o[22]) begin
                nh++;
                if (fhs < 0) fhs = int'(dbus.VGAStr_o[20:11]);
            end
        end
        chk("line_active_cnt", na, 640);
        chk("line_hs_low_cnt", nh, 96);
        chk("line_hs_first_xc", fhs, 656);
        chk("line_end", dbus.VGAStr_o, w(1, 1, 799, 7, 0));
        dstep();
        chk("line_wrap", dbus.VGAStr_o, w(1, 1, 0, 8, 1));
        chk("line_wrap_frame", dbus.frame_o, 0);

        dbus.en = 1'b0;
        nf = 0;
        last = -1;
        for (int c = 0; c < 257; c++) begin
            sm_cycle(1'b1, fr);
            if (fr) begin
                if (last >= 0) chk("sml_frame_period", c - last, 128);
                last = c;
                nf++;
            end
        end
        chk("sml_frame_count", nf, 3);

        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            sm_cycle(1'b1, fr);
            found = fr;
        end
        chk("sml_frame_found", found, 1);
        for (int i = 0; i < 4; i++) sm_cycle(1'b0, fr);
        sm_cycle(1'b1, fr);

        for (int c = 0; c < 150; c++) begin
            sm_cycle($urandom_range(0, 3) != 0, fr);
        end
        for (int c = 0; c < 37; c++) sm_cycle(1'b1, fr);

        rst = 1'b1;
        #1;
        chk("midrst_def_str", dbus.VGAStr_o, w(1, 1, 0, 0, 0));
        chk("midrst_def_frame", dbus.frame_o, 0);
        chk("midrst_sml_str", sbus.VGAStr_o, w(0, 1, 0, 0, 0));
        chk("midrst_sml_frame", sbus.frame_o, 0);
        dbus.en = 1'b1;
        sbus.en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_def_str", dbus.VGAStr_o, w(1, 1, 0, 0, 1));
        chk("post_rst_def_frame", dbus.frame_o, 1);
        chk("post_rst_sml_str", sbus.VGAStr_o, w(0, 1, 0, 0, 1));
        chk("post_rst_sml_frame", sbus.frame_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
